flopoco_to_ieee_sp: RTL and testbench

FLOPOCO_TO_IEEE_SP -- requirements
Module: flopoco_to_ieee_sp

---
 rtl/flopoco_sp_pkg.sv | 81 ++++++++
 rtl/fp_pipe_stage.sv | 45 ++++
 rtl/flopoco_to_ieee_sp.sv | 116 +++++++++++
 tb/tb_flopoco_to_ieee_sp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/flopoco_sp_pkg.sv
// Shared definitions for the FloPoCo -> IEEE-754 binary32 converter.
// Contents:
//   exn_e          : FloPoCo exception field encodings
//   QNAN, EXP_MAX  : IEEE binary32 constants used by the packer
//   flopoco_word_t : field view of a 34-bit FloPoCo single-precision word
//   event_flags_t  : per-word event flags carried down the pipeline
//   s1/s2 payloads : register contents of the two pipeline stages
//   classify()     : derives event flags from exn/exponent
//   pack_ieee()    : maps a FloPoCo word onto an IEEE binary32 word
package flopoco_sp_pkg;

    typedef enum logic [1:0] {
        EXN_ZERO   = 2'b00,
        EXN_NORMAL = 2'b01,
        EXN_INF    = 2'b10,
        EXN_NAN    = 2'b11
    } exn_e;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [7:0]  EXP_MIN = 8'h00;

    typedef struct packed {
        exn_e        exn;
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } flopoco_word_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic ovf;
        logic unf;
    } event_flags_t;

    typedef struct packed {
        flopoco_word_t word;
        event_flags_t  ev;
    } s1_payload_t;

    typedef struct packed {
        logic [31:0]  ieee;
        event_flags_t ev;
    } s2_payload_t;

    // A "normal" FloPoCo word whose exponent sits on either IEEE reserved
    // code cannot be represented as a normal binary32 value: exponent 0 is
    // flushed (underflow), exponent 255 saturates to infinity (overflow).
    function automatic event_flags_t classify(input exn_e exn, input logic [7:0] exponent);
        event_flags_t f;
        f.nan = (exn == EXN_NAN);
        f.inf = (exn == EXN_INF);
        f.ovf = (exn == EXN_NORMAL) && (exponent == EXP_MAX);
        f.unf = (exn == EXN_NORMAL) && (exponent == EXP_MIN);
        return f;
    endfunction

    function automatic logic [31:0] pack_ieee(input flopoco_word_t w);
        logic [31:0] r;
        r = QNAN;
        case (w.exn)
            EXN_ZERO: r = {w.sign, 31'h0000_0000};
            EXN_NORMAL: begin
                if (w.exponent == EXP_MIN) begin
                    r = {w.sign, 31'h0000_0000};
                end else if (w.exponent == EXP_MAX) begin
                    r = {w.sign, EXP_MAX, 23'h00_0000};
                end else begin
                    r = {w.sign, w.exponent, w.fraction};
                end
            end
            EXN_INF: r = {w.sign, EXP_MAX, 23'h00_0000};
            // NaN payload and sign are not preserved: always the canonical quiet NaN.
            EXN_NAN: r = QNAN;
            default: r = QNAN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fp_pipe_stage.sv
// One elastic valid/ready register slice.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   ce                  : clock enable; with ce=0 the slice holds and nothing loads
//   in_valid/in_ready   : upstream handshake, in_data payload (W bits)
//   out_valid/out_ready : downstream handshake, out_data payload (W bits)
// The slice loads whenever it is empty or its content is leaving this cycle,
// so in_ready is a function of local state and out_ready only.
module fp_pipe_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_r;
    logic [W-1:0] data_r;
    logic         load_s;

    assign in_ready  = !valid_r || out_ready;
    assign load_s    = ce && in_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice register: refill (or empty) when loading, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
        end else if (load_s) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/flopoco_to_ieee_sp.sv
// FloPoCo single-precision to IEEE-754 binary32 converter, two-stage
// elastic pipeline with saturating event counters.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   ce                   : clock enable for all state and handshakes
//   in_valid/in_ready, X : input stream of 34-bit FloPoCo words
//   out_valid/out_ready  : output handshake, R_ieee binary32 result
//   clr_cnt              : synchronous counter clear (needs ce=1)
//   cnt_nan/inf/ovf/unf  : saturating counts of emitted words per event
// Stage 1 registers the word with its event flags, stage 2 registers the
// packed IEEE word; counters step when a word leaves stage 2.
module flopoco_to_ieee_sp
    import flopoco_sp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [33:0]      X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      R_ieee,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_nan,
    output logic [CNT_W-1:0] cnt_inf,
    output logic [CNT_W-1:0] cnt_ovf,
    output logic [CNT_W-1:0] cnt_unf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    flopoco_word_t    x_s;
    s1_payload_t      s1_in_s;
    s1_payload_t      s1_out_s;
    s2_payload_t      s2_in_s;
    s2_payload_t      s2_out_s;
    logic             s1_valid_s;
    logic             s2_ready_s;
    logic             xfer_out_s;
    logic [CNT_W-1:0] cnt_nan_r;
    logic [CNT_W-1:0] cnt_inf_r;
    logic [CNT_W-1:0] cnt_ovf_r;
    logic [CNT_W-1:0] cnt_unf_r;

    assign x_s     = flopoco_word_t'(X);
    assign s1_in_s = {x_s, classify(x_s.exn, x_s.exponent)};
    assign s2_in_s = {pack_ieee(s1_out_s.word), s1_out_s.ev};

    fp_pipe_stage #(.W($bits(s1_payload_t))) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_out_s)
    );

    fp_pipe_stage #(.W($bits(s2_payload_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (s2_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out_s)
    );

    assign R_ieee     = s2_out_s.ieee;
    assign xfer_out_s = ce && out_valid && out_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
        if (hit && (c != CNT_MAX)) begin
            return c + CNT_ONE;
        end else begin
            return c;
        end
    endfunction

    // Event counters: clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_nan_r <= CNT_ZERO;
            cnt_inf_r <= CNT_ZERO;
            cnt_ovf_r <= CNT_ZERO;
            cnt_unf_r <= CNT_ZERO;
        end else if (ce) begin
            if (clr_cnt) begin
                cnt_nan_r <= CNT_ZERO;
                cnt_inf_r <= CNT_ZERO;
                cnt_ovf_r <= CNT_ZERO;
                cnt_unf_r <= CNT_ZERO;
            end else begin
                cnt_nan_r <= sat_inc(cnt_nan_r, xfer_out_s && s2_out_s.ev.nan);
                cnt_inf_r <= sat_inc(cnt_inf_r, xfer_out_s && s2_out_s.ev.inf);
                cnt_ovf_r <= sat_inc(cnt_ovf_r, xfer_out_s && s2_out_s.ev.ovf);
                cnt_unf_r <= sat_inc(cnt_unf_r, xfer_out_s && s2_out_s.ev.unf);
            end
        end
    end

    assign cnt_nan = cnt_nan_r;
    assign cnt_inf = cnt_inf_r;
    assign cnt_ovf = cnt_ovf_r;
    assign cnt_unf = cnt_unf_r;

endmodule

// File: tb/tb_flopoco_to_ieee_sp.sv
// Scoreboard bench for flopoco_to_ieee_sp: the driver pushes the expected
// IEEE word when an input transfer happens, the monitor pops and compares
// on every output transfer. Counters use CNT_W=4 so saturation is reachable.
module tb_flopoco_to_ieee_sp;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          in_valid;
    logic          in_ready;
    logic [33:0]   X;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   R_ieee;
    logic          clr_cnt;
    logic [CW-1:0] cnt_nan;
    logic [CW-1:0] cnt_inf;
    logic [CW-1:0] cnt_ovf;
    logic [CW-1:0] cnt_unf;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    logic [31:0]   exp_q[$];

    flopoco_to_ieee_sp #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R_ieee    (R_ieee),
        .clr_cnt   (clr_cnt),
        .cnt_nan   (cnt_nan),
        .cnt_inf   (cnt_inf),
        .cnt_ovf   (cnt_ovf),
        .cnt_unf   (cnt_unf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter for throughput measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: an output transfer completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && ce && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %h, expected no output", R_ieee);
            end else begin
                check("R_ieee", R_ieee, exp_q.pop_front());
            end
        end
    end

    // Drive one word and hold it until accepted (bounded).
    task automatic send(input logic [33:0] x, input logic [31:0] e);
        bit acc = 1'b0;
        in_valid = 1'b1;
        X = x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ce && in_ready) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    logic [33:0] vin  [10] = '{34'h1_3F800000, 34'h3_12345678, 34'h2_80000000, 34'h0_80000000,
                               34'h1_00000001, 34'h1_FF800000, 34'h0_7FFFFFFF, 34'h1_C0490FDB,
                               34'h1_7F7FFFFF, 34'h1_00800000};
    logic [31:0] vexp [10] = '{32'h3F800000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
                               32'h00000000, 32'hFF800000, 32'h00000000, 32'hC0490FDB,
                               32'h7F7FFFFF, 32'h00800000};
    logic [33:0] sw   [4]  = '{34'h1_40000000, 34'h1_40400000, 34'h1_40800000, 34'h1_40A00000};

    initial begin
        int t0;
        int acc;
        int k;
        logic        have_hold;
        logic [31:0] hold;
        logic        ov_s, ir_s;
        logic [31:0] r_s;

        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; X = 34'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_R_ieee", R_ieee, 32'h0);
        check("rst_cnt_nan", {28'd0, cnt_nan}, 32'd0);
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency: out_valid exactly two edges after the accepting edge.
        send(34'h1_3F800000, 32'h3F800000);
        check("lat_1cyc_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_2cyc_valid", {31'd0, out_valid}, 32'd1);
        check("lat_2cyc_data", R_ieee, 32'h3F800000);
        drain();

        // Back-to-back table: one word per cycle.
        t0 = cyc;
        for (int i = 0; i < 10; i++) send(vin[i], vexp[i]);
        check("throughput_cycles", cyc - t0, 32'd10);
        drain();
        check("cnt_nan", {28'd0, cnt_nan}, 32'd1);
        check("cnt_inf", {28'd0, cnt_inf}, 32'd1);
        check("cnt_ovf", {28'd0, cnt_ovf}, 32'd1);
        check("cnt_unf", {28'd0, cnt_unf}, 32'd1);

        // Backpressure: exactly two words buffered, output held stable.
        out_ready = 1'b0; in_valid = 1'b1; k = 0; acc = 0; have_hold = 1'b0; X = sw[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ce && in_ready) begin
                exp_q.push_back(sw[k][31:0]);
                acc++;
                k++;
            end
            @(posedge clk);
            #1;
            X = sw[k];
            if (out_valid && have_hold) check("stall_stable", R_ieee, hold);
            if (out_valid && !have_hold) begin
                hold = R_ieee;
                have_hold = 1'b1;
            end
        end
        check("stall_accepted", acc, 32'd2);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int i = k; i < 4; i++) send(sw[i], sw[i][31:0]);
        drain();

        // Clock enable low: nothing moves.
        send(34'h1_41000000, 32'h41000000);
        send(34'h1_41100000, 32'h41100000);
        ce = 1'b0; in_valid = 1'b1; X = 34'h1_41200000;
        ov_s = out_valid; r_s = R_ieee; ir_s = in_ready;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("ce0_out_valid", {31'd0, out_valid}, {31'd0, ov_s});
            check("ce0_R_ieee", R_ieee, r_s);
            check("ce0_in_ready", {31'd0, in_ready}, {31'd0, ir_s});
        end
        ce = 1'b1;
        send(34'h1_41200000, 32'h41200000);
        drain();

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(34'h1_42000000, 32'h42000000);
        send(34'h1_42100000, 32'h42100000);
        rst = 1'b1;
        #1;
        check("inflight_out_valid", {31'd0, out_valid}, 32'd0);
        check("inflight_R_ieee", R_ieee, 32'h0);
        check("inflight_cnt_nan", {28'd0, cnt_nan}, 32'd0);
        check("inflight_cnt_ovf", {28'd0, cnt_ovf}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Saturation of the NaN counter.
        for (int i = 0; i < 15; i++) send(34'h3_00000000, 32'h7FC00000);
        drain();
        check("cnt_nan_full", {28'd0, cnt_nan}, 32'hF);
        send(34'h3_FFFFFFFF, 32'h7FC00000);
        drain();
        check("cnt_nan_sat", {28'd0, cnt_nan}, 32'hF);

        // Clear wins over a simultaneous counted output.
        out_ready = 1'b0;
        send(34'h3_00000001, 32'h7FC00000);
        @(posedge clk);
        #1;
        clr_cnt = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_cnt_nan", {28'd0, cnt_nan}, 32'd0);
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
